// File: rtl/noc_inject_queue.sv
// Per-VC injection FIFOs feeding a router port through a credit-gated round-robin arbiter.
// Define NOC_INJECT_STATS_EN to build the drop_cnt/sent_cnt statistics counters.
`ifndef NUM_VCS
`define NUM_VCS 2
`endif
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 16
`endif
`ifndef NUM_USER_RECV_PORTS
`define NUM_USER_RECV_PORTS 4
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif

module noc_inject_queue #(
  parameter int unsigned NUM_VCS     = `NUM_VCS,
  parameter int unsigned DATA_W      = `FLIT_DATA_WIDTH,
  parameter int unsigned DEST_BITS   = $clog2(`NUM_USER_RECV_PORTS),
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned CREDIT_INIT = `FLIT_BUFFER_DEPTH,
  localparam int unsigned VCB  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int unsigned FW   = 2 + DEST_BITS + VCB + DATA_W,
  localparam int unsigned CW   = 1 + VCB,
  localparam int unsigned CNTW = $clog2(CREDIT_INIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FW-1:0]      flit_in,
  output logic [NUM_VCS-1:0] vc_ready,
  output logic [FW-1:0]      flit_out,
  input  logic [CW-1:0]      credit_in,
  output logic               overflow,
  output logic               credit_err,
  output logic [15:0]        drop_cnt,
  output logic [31:0]        sent_cnt
);

  localparam int unsigned QW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned OW  = QW + 1;
  localparam int unsigned EW  = 1 + DEST_BITS + DATA_W;
  localparam int unsigned VCN = 1 << VCB;
  localparam logic [VCN-1:0] VC_LEGAL = VCN'((64'(1) << NUM_VCS) - 64'(1));

  logic [EW-1:0]   r_mem    [NUM_VCS][QUEUE_DEPTH];
  logic [QW-1:0]   r_wptr   [NUM_VCS];
  logic [QW-1:0]   r_rptr   [NUM_VCS];
  logic [OW-1:0]   r_occ    [NUM_VCS];
  logic [CNTW-1:0] r_credit [NUM_VCS];
  logic [VCB-1:0]  r_rr;
  logic [FW-1:0]   r_flit_out;
  logic            r_overflow;
  logic            r_credit_err;

  logic               w_in_valid, w_in_ok, w_in_full, w_drop;
  logic               w_cr_valid, w_cr_ok, w_cr_err;
  logic [VCB-1:0]     w_in_vc, w_cr_vc;
  logic [EW-1:0]      w_in_entry, w_head;
  logic [NUM_VCS-1:0] w_push, w_pop, w_cr_inc, w_elig, w_at_init;
  logic               w_gnt_valid;
  logic [VCB-1:0]     w_gnt, w_rr_next;
  logic [VCB:0]       w_scan;

  assign w_in_valid = flit_in[FW-1];
  assign w_in_vc    = flit_in[DATA_W +: VCB];
  assign w_in_entry = {flit_in[FW-2 -: 1+DEST_BITS], flit_in[DATA_W-1:0]};
  assign w_in_ok    = VC_LEGAL[w_in_vc];
  assign w_in_full  = (r_occ[w_in_vc] == OW'(QUEUE_DEPTH));
  assign w_drop     = w_in_valid && w_in_ok && w_in_full;
  assign w_cr_valid = credit_in[CW-1];
  assign w_cr_vc    = credit_in[VCB-1:0];
  assign w_cr_ok    = VC_LEGAL[w_cr_vc];
  assign w_cr_err   = |(w_cr_inc & ~w_pop & w_at_init);

  // Per-VC push, credit-return and eligibility decode from pre-edge state
  always_comb begin
    w_push    = '0;
    w_cr_inc  = '0;
    w_elig    = '0;
    w_at_init = '0;
    vc_ready  = '0;
    for (int v = 0; v < int'(NUM_VCS); v++) begin
      w_elig[v]    = (r_occ[v] != '0) && (r_credit[v] != '0);
      w_push[v]    = w_in_valid && w_in_ok && !w_in_full && (w_in_vc == VCB'(v));
      w_cr_inc[v]  = w_cr_valid && w_cr_ok && (w_cr_vc == VCB'(v));
      w_at_init[v] = (r_credit[v] == CNTW'(CREDIT_INIT));
      vc_ready[v]  = (r_occ[v] != OW'(QUEUE_DEPTH));
    end
  end

  // Round-robin: first eligible VC scanning upward from r_rr with wrap
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_scan      = '0;
    w_pop       = '0;
    for (int k = 0; k < int'(NUM_VCS); k++) begin
      w_scan = (VCB+1)'(r_rr) + (VCB+1)'(k);
      if (w_scan >= (VCB+1)'(NUM_VCS)) w_scan = w_scan - (VCB+1)'(NUM_VCS);
      if (!w_gnt_valid && w_elig[w_scan[VCB-1:0]]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = w_scan[VCB-1:0];
      end
    end
    for (int v = 0; v < int'(NUM_VCS); v++) w_pop[v] = w_gnt_valid && (w_gnt == VCB'(v));
  end

  assign w_head    = r_mem[w_gnt][r_rptr[w_gnt]];
  assign w_rr_next = (w_gnt == VCB'(NUM_VCS - 1)) ? '0 : w_gnt + VCB'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < int'(NUM_VCS); v++) begin
        r_wptr[v]   <= '0;
        r_rptr[v]   <= '0;
        r_occ[v]    <= '0;
        r_credit[v] <= CNTW'(CREDIT_INIT);
      end
      r_rr         <= '0;
      r_flit_out   <= '0;
      r_overflow   <= 1'b0;
      r_credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < int'(NUM_VCS); v++) begin
        if (w_push[v]) r_wptr[v] <= r_wptr[v] + QW'(1);
        if (w_pop[v])  r_rptr[v] <= r_rptr[v] + QW'(1);
        if (w_push[v] != w_pop[v])
          r_occ[v] <= w_push[v] ? r_occ[v] + OW'(1) : r_occ[v] - OW'(1);
        // A return that coincides with a grant on the same VC cancels out
        if (w_pop[v] && !w_cr_inc[v])
          r_credit[v] <= r_credit[v] - CNTW'(1);
        else if (w_cr_inc[v] && !w_pop[v] && !w_at_init[v])
          r_credit[v] <= r_credit[v] + CNTW'(1);
      end
      if (w_drop)   r_overflow   <= 1'b1;
      if (w_cr_err) r_credit_err <= 1'b1;
      if (w_gnt_valid) begin
        r_rr       <= w_rr_next;
        r_flit_out <= {1'b1, w_head[EW-1 -: 1+DEST_BITS], w_gnt, w_head[DATA_W-1:0]};
      end else begin
        r_flit_out <= '0;
      end
    end
  end

  // Payload storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < int'(NUM_VCS); v++)
        if (w_push[v]) r_mem[v][r_wptr[v]] <= w_in_entry;
    end
  end

  assign flit_out   = r_flit_out;
  assign overflow   = r_overflow;
  assign credit_err = r_credit_err;

`ifdef NOC_INJECT_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [31:0] r_sent_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_sent_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_gnt_valid) r_sent_cnt <= r_sent_cnt + 32'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign sent_cnt = r_sent_cnt;
`else
  assign drop_cnt = '0;
  assign sent_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_inject_queue.sv
// Directed bench for noc_inject_queue with a queue-based reference model checked every cycle.
module tb_noc_inject_queue;
  localparam int unsigned NV = 3, DW = 16, DB = 2, QD = 4, CI = 4;
  localparam int unsigned VB = 2, FW = 2 + DB + VB + DW, CW = 1 + VB;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] flit_in;
  logic [NV-1:0] vc_ready;
  logic [FW-1:0] flit_out;
  logic [CW-1:0] credit_in;
  logic          overflow, credit_err;
  logic [15:0]   drop_cnt;
  logic [31:0]   sent_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  noc_inject_queue #(.NUM_VCS(NV), .DATA_W(DW), .DEST_BITS(DB), .QUEUE_DEPTH(QD),
                     .CREDIT_INIT(CI)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .vc_ready(vc_ready), .flit_out(flit_out),
    .credit_in(credit_in), .overflow(overflow), .credit_err(credit_err),
    .drop_cnt(drop_cnt), .sent_cnt(sent_cnt));

  function automatic logic [FW-1:0] mkflit(input logic tail, input logic [DB-1:0] dest,
                                           input logic [VB-1:0] vc, input logic [DW-1:0] data);
    return {1'b1, tail, dest, vc, data};
  endfunction

  function automatic logic [CW-1:0] mkcred(input logic [VB-1:0] vc);
    return {1'b1, vc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain queues of whole flits and integer credit counts
  logic [FW-1:0] mq [NV][$];
  int            mcred [NV];
  int            mrr;
  logic [FW-1:0] m_out;
  bit            m_ovf, m_cerr, m_live = 1'b0;
  int            m_drop, m_sent;

  always @(posedge clk) begin : model
    int g, fvc, cvc, v;
    bit do_push;
    if (rst) begin
      for (int i = 0; i < NV; i++) begin
        mq[i].delete();
        mcred[i] = CI;
      end
      mrr = 0; m_out = '0; m_ovf = 0; m_cerr = 0; m_drop = 0; m_sent = 0; m_live = 1'b1;
    end else if (m_live) begin
      fvc = int'(flit_in[DW +: VB]);
      cvc = int'(credit_in[VB-1:0]);
      do_push = 1'b0;
      if (flit_in[FW-1] && fvc < NV) begin
        if (mq[fvc].size() < QD) do_push = 1'b1;
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      g = -1;
      for (int k = 0; k < NV; k++) begin
        v = (mrr + k) % NV;
        if (g < 0 && mq[v].size() > 0 && mcred[v] > 0) g = v;
      end
      if (g >= 0) begin
        m_out = mq[g].pop_front();
        mcred[g]--;
        mrr = (g + 1) % NV;
        m_sent++;
      end else m_out = '0;
      if (do_push) mq[fvc].push_back(flit_in);
      if (credit_in[CW-1] && cvc < NV) begin
        mcred[cvc]++;
        if (mcred[cvc] > CI) begin
          mcred[cvc] = CI;
          m_cerr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [NV-1:0] er;
    if (m_live) begin
      for (int i = 0; i < NV; i++) er[i] = (mq[i].size() != QD);
      check("model_flit_out", flit_out, m_out);
      check("model_vc_ready", vc_ready, er);
      check("model_overflow", overflow, m_ovf);
      check("model_credit_err", credit_err, m_cerr);
`ifdef NOC_INJECT_STATS_EN
      check("model_drop_cnt", drop_cnt, m_drop);
      check("model_sent_cnt", sent_cnt, m_sent);
`else
      check("model_drop_cnt", drop_cnt, 0);
      check("model_sent_cnt", sent_cnt, 0);
`endif
    end
  end

  logic [FW-1:0] outs [$];

  task automatic cyc(input logic [FW-1:0] f, input logic [CW-1:0] c);
    flit_in = f;
    credit_in = c;
    @(negedge clk);
    if (flit_out[FW-1]) outs.push_back(flit_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc('0, '0);
    cyc(mkflit(1'b1, 2'd1, 2'd0, 16'h1234), mkcred(2'd0));
    rst = 1'b0;
    outs.delete();
  endtask

  initial begin
    logic [DW-1:0] ed;
    rst = 1'b1;
    flit_in = '0;
    credit_in = '0;

    // Reset values and two-cycle latency of a single flit
    do_reset();
    check("reset_vc_ready", vc_ready, 3'b111);
    check("reset_flit_out", flit_out, 0);
    check("reset_overflow", overflow, 0);
    cyc(mkflit(1'b1, 2'd0, 2'd0, 16'hBEEF), '0);
    check("lat_not_early", flit_out, 0);
    cyc('0, '0);
    check("beef_out", flit_out, 22'h30BEEF);
`ifdef NOC_INJECT_STATS_EN
    check("beef_sent_cnt", sent_cnt, 1);
`endif
    cyc('0, mkcred(2'd0));
    check("credit_back_ok", credit_err, 0);
    cyc('0, mkcred(2'd0));
    check("credit_over", credit_err, 1);

    // Credit limit: 6 flits, 4 credits
    do_reset();
    for (int i = 0; i < 6; i++) cyc(mkflit(1'(i == 5), 2'd0, 2'd0, 16'(i)), '0);
    idle(4);
    check("credit_limit_count", outs.size(), 4);
    check("held_ready", vc_ready[0], 1);
    cyc('0, mkcred(2'd0));
    cyc('0, '0);
    check("fifth_after_credit", flit_out, mkflit(1'b0, 2'd0, 2'd0, 16'd4));

    // Full queue on vc1 with no credit
    do_reset();
    for (int i = 0; i < 4; i++) cyc(mkflit(1'b0, 2'd2, 2'd1, 16'(i)), '0);
    idle(3);
    for (int i = 0; i < 4; i++) cyc(mkflit(1'b0, 2'd2, 2'd1, 16'(16'h100 + i)), '0);
    check("full_ready", vc_ready, 3'b101);
    check("no_ovf_yet", overflow, 0);
    cyc(mkflit(1'b1, 2'd2, 2'd1, 16'h1FF), '0);
    check("ovf_set", overflow, 1);
`ifdef NOC_INJECT_STATS_EN
    check("drop_cnt_one", drop_cnt, 1);
`else
    check("drop_cnt_off", drop_cnt, 0);
`endif

    // Round-robin alternation between vc0 and vc1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(mkflit(1'b0, 2'd0, 2'd0, 16'(i)), '0);
      cyc(mkflit(1'b0, 2'd0, 2'd1, 16'(i)), '0);
    end
    idle(3);
    for (int i = 0; i < 3; i++) cyc(mkflit(1'b0, 2'd1, 2'd0, 16'(16'hA0 + i)), '0);
    for (int i = 0; i < 3; i++) cyc(mkflit(1'b0, 2'd3, 2'd1, 16'(16'hB0 + i)), '0);
    outs.delete();
    for (int i = 0; i < 3; i++) begin
      cyc('0, mkcred(2'd0));
      cyc('0, mkcred(2'd1));
    end
    idle(4);
    check("rr_count", outs.size(), 6);
    for (int j = 0; j < 6 && j < outs.size(); j++) begin
      ed = 16'(((j % 2) != 0 ? 16'hB0 : 16'hA0) + j / 2);
      check("rr_vc", outs[j][DW +: VB], j % 2);
      check("rr_data", outs[j][DW-1:0], ed);
    end

    // Credit error right after reset; grant and return on one edge
    do_reset();
    cyc('0, mkcred(2'd0));
    check("cerr_after_reset", credit_err, 1);
    do_reset();
    check("cerr_cleared", credit_err, 0);
    cyc(mkflit(1'b0, 2'd0, 2'd0, 16'h0011), '0);
    idle(2);
    cyc(mkflit(1'b0, 2'd0, 2'd0, 16'h0022), '0);
    cyc('0, mkcred(2'd0));
    check("sim_grant", flit_out, mkflit(1'b0, 2'd0, 2'd0, 16'h0022));
    cyc('0, mkcred(2'd0));
    check("sim_no_err", credit_err, 0);
    cyc('0, mkcred(2'd0));
    check("sim_err", credit_err, 1);

    // Reset with flits queued discards them
    do_reset();
    for (int i = 0; i < 4; i++) cyc(mkflit(1'b0, 2'd0, 2'd0, 16'(i)), '0);
    idle(3);
    cyc(mkflit(1'b0, 2'd0, 2'd0, 16'h0C01), '0);
    cyc(mkflit(1'b1, 2'd0, 2'd0, 16'h0C02), '0);
    outs.delete();
    rst = 1'b1;
    cyc(mkflit(1'b0, 2'd0, 2'd2, 16'h0D00), mkcred(2'd2));
    check("rst_flit_out", flit_out, 0);
    check("rst_vc_ready", vc_ready, 3'b111);
    rst = 1'b0;
    idle(6);
    check("rst_no_emit", outs.size(), 0);

    // Out-of-range VC on flit and credit is ignored
    do_reset();
    cyc(mkflit(1'b0, 2'd0, 2'd3, 16'h5555), mkcred(2'd3));
    idle(3);
    check("bad_vc_no_emit", outs.size(), 0);
    check("bad_vc_no_ovf", overflow, 0);
    check("bad_vc_no_cerr", credit_err, 0);
    check("bad_vc_ready", vc_ready, 3'b111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/noc_inject_queue.md
NOC_INJECT_QUEUE -- requirements
Module: noc_inject_queue

Interface
REQ-001 Parameter NUM_VCS, default `NUM_VCS, number of virtual channels.
REQ-002 Parameter DATA_W, default `FLIT_DATA_WIDTH, flit payload width.
REQ-003 Parameter DEST_BITS, default $clog2(`NUM_USER_RECV_PORTS), destination field width.
REQ-004 Parameter QUEUE_DEPTH, default 4, per-VC queue entries (power of two, >=2).
REQ-005 Parameter CREDIT_INIT, default `FLIT_BUFFER_DEPTH, router buffer slots per VC.
REQ-006 Derived: VCB = max(1,$clog2(NUM_VCS)); FW = 2+DEST_BITS+VCB+DATA_W; CW = 1+VCB; CNTW = $clog2(CREDIT_INIT+1).
REQ-007 clk  in  1  single clock, all state updates on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 flit_in  in  FW  PE flit {valid,tail,dest,vc,data}, valid = MSB.
REQ-010 vc_ready  out  NUM_VCS  bit v high = VC v queue not full.
REQ-011 flit_out  out  FW  flit to router, same field layout.
REQ-012 credit_in  in  CW  router credit {valid,vc}, valid = MSB.
REQ-013 overflow  out  1  sticky: a flit was dropped on a full queue.
REQ-014 credit_err  out  1  sticky: credit received with counter already at CREDIT_INIT.
REQ-015 drop_cnt  out  16  dropped-flit count (see Configuration).
REQ-016 sent_cnt  out  32  flits-sent count (see Configuration).

Function
REQ-017 Per-VC circular FIFO, QUEUE_DEPTH entries, stores {tail,dest,data}; read/write pointers wrap modulo QUEUE_DEPTH; occupancy counter 0..QUEUE_DEPTH.
REQ-018 flit_in valid at edge -> push into queue of flit_in.vc if that queue's registered occupancy < QUEUE_DEPTH; full test uses pre-edge occupancy, so push to a full queue is rejected even if the same VC pops that edge.
REQ-019 Rejected push: flit discarded, overflow set, drop_cnt incremented (saturate at 16'hFFFF).
REQ-020 vc_ready[v] = (occupancy[v] != QUEUE_DEPTH), combinational from registered state.
REQ-021 Per-VC credit counter, CNTW bits; VC eligible iff queue non-empty and credit > 0.
REQ-022 Round-robin arbiter: grant first eligible VC at or after rr_ptr (wrapping); on grant rr_ptr <= granted+1 mod NUM_VCS; no grant -> rr_ptr holds.
REQ-023 Grant at edge: pop head, flit_out <= {1'b1,tail,dest,granted vc,data}, credit[granted] decremented; no grant -> flit_out <= 0.
REQ-024 flit_out registered; latency: flit sampled at edge E into empty queue with credit available appears on flit_out after edge E+1 (2 cycles); at most one flit per cycle.
REQ-025 credit_in valid at edge -> credit[credit_in.vc] incremented; if already CREDIT_INIT, counter holds and credit_err set.
REQ-026 Same-VC grant and credit return on one edge -> counter unchanged (also when at 0 or CREDIT_INIT-1); push and pop same non-full VC on one edge -> occupancy unchanged.
REQ-027 Push into an empty queue is not visible to the arbiter until the following edge (no bypass).
REQ-028 vc field >= NUM_VCS on flit_in or credit_in -> ignored, no state change.
REQ-029 sent_cnt increments on every grant, wraps at 2^32.

Reset
REQ-030 rst high at edge: all queues empty, pointers 0, credit[v] = CREDIT_INIT, rr_ptr = 0, flit_out = 0, overflow = 0, credit_err = 0, drop_cnt = 0, sent_cnt = 0.
REQ-031 vc_ready all ones in the cycle after reset; rst asserted mid-operation discards queued flits without emission; inputs ignored while rst high.

Configuration
REQ-032 Macro NOC_INJECT_STATS_EN defined: drop_cnt and sent_cnt counters implemented per REQ-019/REQ-029.
REQ-033 Macro undefined: counter registers not built, drop_cnt and sent_cnt tied to 0; overflow, credit_err and all other behaviour unchanged.

Verification
REQ-034 Reset, one flit vc0 data 16'hBEEF dest 0 -> flit_out valid with same fields 2 cycles later, credit[0] = CREDIT_INIT-1, sent_cnt = 1.
REQ-035 CREDIT_INIT=4, no credit returns, 6 flits vc0 -> exactly 4 emitted, 2 held, vc_ready[0] stays 1; one credit returned -> 5th emitted next cycle.
REQ-036 Credits withheld, 5 flits vc1 with QUEUE_DEPTH=4 -> vc_ready[1] low after 4th, 5th dropped, overflow = 1, drop_cnt = 1 (0 without NOC_INJECT_STATS_EN).
REQ-037 Queues vc0 and vc1 each hold 3 flits, full credit -> outputs alternate vc0,vc1,vc0,vc1,vc0,vc1.
REQ-038 credit_in valid vc0 right after reset -> credit_err = 1, credit[0] stays CREDIT_INIT; simultaneous grant and credit on vc0 -> counter unchanged.
REQ-039 rst asserted with 2 flits queued -> flit_out 0, vc_ready all ones, no queued flit ever emitted.
